uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: STOP_BITS, default 1, number of stop-bit cycles per frame (legal values 1 or 2).
REQ-002 Port: clck, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, reset; synchronous, active-high.
REQ-004 Port: p_data, input, 8, byte to transmit; sampled only on acceptance.
REQ-005 Port: data_valid, input, 1, request to transmit p_data.
REQ-006 Port: par_en, input, 1, parity bit inserted when 1; sampled on acceptance.
REQ-007 Port: par_typ, input, 1, parity type, 0 = even and 1 = odd; sampled on acceptance.
REQ-008 Port: ser_done, input, 1, from the serializer; high in the cycle its last data bit (bit 7) is on ser_data.
REQ-009 Port: ser_data, input, 1, serial data bit from the serializer.
REQ-010 Port: ser_p_data, output, 8, latched byte to the serializer; held stable for the whole frame.
REQ-011 Port: ser_en, output, 1, one-cycle load pulse to the serializer.
REQ-012 Port: mux_sel, output, 2, frame-bit select: 00 = start, 01 = stop/idle, 10 = data, 11 = parity.
REQ-013 Port: tx_out, output, 1, serial line, driven combinationally from mux_sel, ser_data and the parity register.
REQ-014 Port: busy, output, 1, high in every state except IDLE.
REQ-015 Port: ser_err, output, 1, sticky flag set when the serializer fails to signal completion on time.

Function
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with one clck per line bit.
REQ-017 In IDLE, data_valid=1 SHALL:
- latch p_data into ser_p_data;
- latch par_en;
- latch the parity bit, computed as XOR of p_data XOR par_typ;
- clear ser_err;
- go to START.
REQ-018 data_valid while busy=1 SHALL be ignored; nothing is queued.
REQ-019 START SHALL last one cycle, with mux_sel=00, tx_out=0 and ser_en=1; ser_en SHALL be 0 in every other state.
REQ-020 DATA SHALL present tx_out=ser_data with mux_sel=10, and keep a 3-bit count that is 0 on entry and increments each DATA cycle.
REQ-021 DATA SHALL exit when ser_done=1 or when the count reaches 7, whichever comes first; it SHALL never exceed 8 cycles.
REQ-022 If the count reaches 7 while ser_done=0, ser_err SHALL be set at that edge.
REQ-023 If ser_done=1 arrives before the count reaches 7, DATA SHALL exit early and ser_err SHALL be set.
REQ-024 On DATA exit, the next state SHALL be PARITY if the latched par_en=1, otherwise STOP.
REQ-025 PARITY SHALL last one cycle, with mux_sel=11 and tx_out equal to the latched parity bit.
REQ-026 STOP SHALL last STOP_BITS cycles, with mux_sel=01 and tx_out=1, then go to IDLE.
REQ-027 IDLE SHALL drive mux_sel=01, tx_out=1 and busy=0.
REQ-028 Frame timing: data_valid at cycle 0 SHALL give START at cycle 1, DATA at cycles 2-9, PARITY at cycle 10 (when enabled), and STOP after that.
REQ-029 The earliest next acceptance SHALL be the first IDLE cycle after STOP; there is no back-to-back frame from STOP.

Reset
REQ-030 rst=1 at any cycle, including mid-frame, SHALL at the next edge force:
- state IDLE and count 0;
- ser_p_data=0, parity register 0, latched par_en 0;
- ser_err=0.
REQ-031 As a result of that reset, outputs SHALL be tx_out=1, mux_sel=01, ser_en=0 and busy=0.
REQ-032 rst SHALL take priority over data_valid in the same cycle.

Configuration
REQ-033 Macro UART_TX_PARITY_EN compiled in SHALL enable parity exactly as above.
REQ-034 With UART_TX_PARITY_EN not defined:
- the PARITY state and parity register SHALL be absent;
- par_en and par_typ SHALL be ignored;
- DATA SHALL always exit to STOP;
- mux_sel=11 SHALL never occur.

Verification
REQ-035 Reset, then p_data=0xA5, par_en=1, par_typ=0, STOP_BITS=1 -> tx_out from cycle 1 = 0,1,0,1,0,0,1,0,1,0,1, with busy high for cycles 1-11 and low at cycle 12.
REQ-036 Same as REQ-035 with par_typ=1 -> parity bit at cycle 10 = 1; with par_en=0 -> no PARITY state, STOP at cycle 10, IDLE at cycle 11.
REQ-037 STOP_BITS=2, p_data=0xFF, par_en=0 -> tx_out = 0 then eleven 1s (eight data, two stop, back to idle); busy low from cycle 12.
REQ-038 rst=1 at cycle 5 of a frame -> at cycle 6 tx_out=1, busy=0, ser_en=0, and the next data_valid starts a clean frame.
REQ-039 ser_done held low -> DATA lasts exactly 8 cycles, ser_err=1 and stays set; the next accepted frame clears ser_err.
REQ-040 data_valid held high during a frame -> no retrigger; a new START occurs only in the first cycle after IDLE is reached.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : uart_tx_ctrl_if                                              |
// | Brief  : Request/serializer/line bundle between a requester and the   |
// |          uart_tx_ctrl frame controller.                               |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface uart_tx_ctrl_if;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       ser_done;
  logic       ser_data;
  logic [7:0] ser_p_data;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       tx_out;
  logic       busy;
  logic       ser_err;

  modport master (
    output p_data, data_valid, par_en, par_typ, ser_done, ser_data,
    input  ser_p_data, ser_en, mux_sel, tx_out, busy, ser_err
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, ser_done, ser_data,
    output ser_p_data, ser_en, mux_sel, tx_out, busy, ser_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : uart_tx_ctrl                                                 |
// | Brief  : UART transmit frame controller (start/data/parity/stop).     |
// |          Parity support compiled in with UART_TX_PARITY_EN.           |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module uart_tx_ctrl #(
  parameter int STOP_BITS = 1
) (
  input  logic          clck,
  input  logic          rst,
  uart_tx_ctrl_if.slave tx_bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  localparam logic c_STOP_LAST = (STOP_BITS == 2);

  state_t     r_state;
  state_t     w_next;
  state_t     w_after_data;
  logic [2:0] r_cnt;
  logic       r_stop_cnt;
  logic [7:0] r_pdata;
  logic       r_err;
  logic       w_accept;
  logic       w_data_exit;
  logic       w_err_set;
  logic       w_ser_en;
  logic       w_tx;
  logic [1:0] w_mux;

  assign w_accept    = (r_state == S_IDLE) && tx_bus.data_valid;
  assign w_data_exit = (r_state == S_DATA) && (tx_bus.ser_done || (r_cnt == 3'd7));
  // Error when completion and the eighth bit disagree: done early, or missing at bit 7.
  assign w_err_set   = (r_state == S_DATA) && (tx_bus.ser_done != (r_cnt == 3'd7));

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;

  always_ff @(posedge clck) begin
    if (rst) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_par_en  <= tx_bus.par_en;
      r_par_bit <= (^tx_bus.p_data) ^ tx_bus.par_typ;
    end
  end

  assign w_after_data = r_par_en ? S_PARITY : S_STOP;
`else
  logic w_unused_par;
  assign w_unused_par = tx_bus.par_en ^ tx_bus.par_typ;
  assign w_after_data = S_STOP;
`endif

  always_comb begin
    w_next   = r_state;
    w_ser_en = 1'b0;
    w_mux    = 2'b01;
    w_tx     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (tx_bus.data_valid) w_next = S_START;
      end
      S_START: begin
        w_ser_en = 1'b1;
        w_mux    = 2'b00;
        w_tx     = 1'b0;
        w_next   = S_DATA;
      end
      S_DATA: begin
        w_mux = 2'b10;
        w_tx  = tx_bus.ser_data;
        if (w_data_exit) w_next = w_after_data;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_mux  = 2'b11;
        w_tx   = r_par_bit;
        w_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (r_stop_cnt == c_STOP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_pdata    <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= ((r_state == S_DATA) && !w_data_exit) ? r_cnt + 3'd1 : 3'd0;
      r_stop_cnt <= ((r_state == S_STOP) && (w_next == S_STOP)) ? 1'b1 : 1'b0;
      if (w_accept) begin
        r_pdata <= tx_bus.p_data;
        r_err   <= 1'b0;
      end else if (w_err_set) begin
        r_err   <= 1'b1;
      end
    end
  end

  assign tx_bus.ser_p_data = r_pdata;
  assign tx_bus.ser_en     = w_ser_en;
  assign tx_bus.mux_sel    = w_mux;
  assign tx_bus.tx_out     = w_tx;
  assign tx_bus.busy       = (r_state != S_IDLE);
  assign tx_bus.ser_err    = r_err;

endmodule
`default_nettype wire
